// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake bundle between a controller and the restoring divider.
// The controller drives start and the operands; the divider returns status and results.
interface seq_restoring_divider_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, WIDTH cycles per divide.
// A zero divisor short-circuits to an all-ones quotient with the dividend as remainder.
//
//   state | meaning
//   IDLE  | waiting for start; results held
//   RUN   | shift-and-subtract iterations, busy high
//   DONE  | one-cycle done pulse; start accepted here too
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input logic                    clk,
    input logic                    rst,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             accept;

    // The partial remainder never exceeds the divisor, so its MSB is zero before each shift.
    always_comb begin
        shifted = {prem_q[WIDTH-1:0], shreg_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr_q};
        accept  = bus.start && (state_q != RUN);
    end

    always_comb begin
        state_d = state_q;
        prem_d  = prem_q;
        shreg_d = shreg_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            RUN: begin
                prem_d  = trial[WIDTH] ? shifted : trial;
                shreg_d = {shreg_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quo_d   = shreg_d;
                    rem_d   = prem_d[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    if (bus.divisor != '0) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        prem_d  = '0;
                        shreg_d = bus.dividend;
                        dvsr_d  = bus.divisor;
                        cnt_d   = '0;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        quo_d   = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prem_q  <= '0;
            shreg_q <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prem_q  <= prem_d;
            shreg_q <= shreg_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy_q && done_q));
    a_prem_bounded:   assert property (@(posedge clk) disable iff (rst)
                                       (state_q == RUN) |-> (prem_q[WIDTH] == 1'b0));
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for the restoring divider at WIDTH=4 (directed + exhaustive) and WIDTH=8 (random).
// Expected results come from plain / and % with the zero-divisor rule, popped by per-DUT monitors on done.
module tb_seq_restoring_divider;
    logic clk;
    logic rst;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         cyc;
    } exp_t;

    exp_t       sb4[$];
    exp_t       sb8[$];
    logic [7:0] last_q;
    logic [7:0] last_r;
    logic       last_dbz;

    seq_restoring_divider_if #(.WIDTH(4)) bus4 ();
    seq_restoring_divider_if #(.WIDTH(8)) bus8 ();

    seq_restoring_divider #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    seq_restoring_divider #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at the negedge where start is driven; the accepting edge follows.
    function automatic exp_t model(input int w, input int a, input int b, input int c);
        exp_t e;
        if (b == 0) begin
            e.q   = 8'((1 << w) - 1);
            e.r   = 8'(a);
            e.dbz = 1'b1;
            e.cyc = c + 1;
        end else begin
            e.q   = 8'(a / b);
            e.r   = 8'(a % b);
            e.dbz = 1'b0;
            e.cyc = c + w + 1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        chk("busy_done_excl4", int'(bus4.busy & bus4.done), 0);
        if (bus4.done) begin
            if (sb4.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_done4: got done at cycle %0d, expected no done", cyc);
            end else begin
                e = sb4.pop_front();
                chk("quotient4", int'(bus4.quotient), int'(e.q));
                chk("remainder4", int'(bus4.remainder), int'(e.r));
                chk("div_by_zero4", int'(bus4.div_by_zero), int'(e.dbz));
                chk("latency4", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        chk("busy_done_excl8", int'(bus8.busy & bus8.done), 0);
        if (bus8.done) begin
            if (sb8.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_done8: got done at cycle %0d, expected no done", cyc);
            end else begin
                e = sb8.pop_front();
                chk("quotient8", int'(bus8.quotient), int'(e.q));
                chk("remainder8", int'(bus8.remainder), int'(e.r));
                chk("div_by_zero8", int'(bus8.div_by_zero), int'(e.dbz));
                chk("latency8", cyc, e.cyc);
            end
        end
    end

    // Entered and left at a negedge; returns on the cycle done is visible.
    task automatic run4(input int a, input int b);
        exp_t e;
        int   busy_cnt = 0;
        bit   got = 1'b0;
        e = model(4, a, b, cyc);
        sb4.push_back(e);
        last_q   = e.q;
        last_r   = e.r;
        last_dbz = e.dbz;
        bus4.start    = 1'b1;
        bus4.dividend = 4'(a);
        bus4.divisor  = 4'(b);
        @(negedge clk);
        bus4.start    = 1'b0;
        bus4.dividend = 4'($urandom);
        bus4.divisor  = 4'($urandom);
        for (int i = 0; i < 40; i++) begin
            if (bus4.busy) busy_cnt++;
            if (bus4.done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("timeout4", int'(got), 1);
        chk("busy_cycles4", busy_cnt, (b == 0) ? 0 : 4);
    endtask

    task automatic run8(input int a, input int b);
        exp_t e;
        int   busy_cnt = 0;
        bit   got = 1'b0;
        e = model(8, a, b, cyc);
        sb8.push_back(e);
        bus8.start    = 1'b1;
        bus8.dividend = 8'(a);
        bus8.divisor  = 8'(b);
        @(negedge clk);
        bus8.start    = 1'b0;
        bus8.dividend = 8'($urandom);
        bus8.divisor  = 8'($urandom);
        for (int i = 0; i < 40; i++) begin
            if (bus8.busy) busy_cnt++;
            if (bus8.done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("timeout8", int'(got), 1);
        chk("busy_cycles8", busy_cnt, (b == 0) ? 0 : 8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        rst = 1'b1;
        bus4.start = 1'b0; bus4.dividend = '0; bus4.divisor = '0;
        bus8.start = 1'b0; bus8.dividend = '0; bus8.divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy4", int'(bus4.busy), 0);
        chk("rst_done4", int'(bus4.done), 0);
        chk("rst_quotient4", int'(bus4.quotient), 0);
        chk("rst_remainder4", int'(bus4.remainder), 0);
        chk("rst_dbz4", int'(bus4.div_by_zero), 0);
        chk("rst_quotient8", int'(bus8.quotient), 0);
        #2 rst = 1'b0;
        @(negedge clk);

        run4(13, 3);
        run4(15, 1);
        run4(2, 9);
        run4(15, 15);
        run4(0, 5);
        run4(7, 0);
        run4(6, 2);

        repeat (20) begin
            @(negedge clk);
            chk("hold_quotient", int'(bus4.quotient), int'(last_q));
            chk("hold_remainder", int'(bus4.remainder), int'(last_r));
            chk("hold_dbz", int'(bus4.div_by_zero), int'(last_dbz));
        end

        // Start pulsed mid-RUN with new operands must be ignored entirely.
        sb4.push_back(model(4, 12, 5, cyc));
        bus4.start = 1'b1; bus4.dividend = 4'd12; bus4.divisor = 4'd5;
        @(negedge clk);
        bus4.start = 1'b0; bus4.dividend = 4'd0; bus4.divisor = 4'd0;
        @(negedge clk);
        bus4.start = 1'b1; bus4.dividend = 4'd9; bus4.divisor = 4'd3;
        @(negedge clk);
        bus4.start = 1'b0; bus4.dividend = 4'($urandom); bus4.divisor = 4'($urandom);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus4.done) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("timeout_protocol", got, 1);
        repeat (12) @(negedge clk);

        // Asynchronous reset in RUN cycle 2 aborts the divide.
        sb4.push_back(model(4, 11, 2, cyc));
        bus4.start = 1'b1; bus4.dividend = 4'd11; bus4.divisor = 4'd2;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        chk("busy_before_abort", int'(bus4.busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", int'(bus4.busy), 0);
        chk("abort_done", int'(bus4.done), 0);
        chk("abort_quotient", int'(bus4.quotient), 0);
        chk("abort_remainder", int'(bus4.remainder), 0);
        chk("abort_dbz", int'(bus4.div_by_zero), 0);
        sb4.delete();
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (8) @(negedge clk);
        run4(11, 2);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run4(a, b);
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
        end

        for (int n = 0; n < 1000; n++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, 255));
            run8(a, b);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (12) @(negedge clk);
        chk("pending4", sb4.size(), 0);
        chk("pending8", sb8.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
